// File: rtl/operand_adder_seq.sv
// operand_adder_seq: front end for the two-operand signed adder display.
// Captures two 4-bit two's-complement operands from the switches on debounced
// key presses, then computes a 4-bit sum and a signed-overflow flag.
// Ports:
//   clk, rst_n       - clock, asynchronous active-low reset
//   sw[3:0]          - operand switches (asynchronous)
//   key_n            - raw pushbutton, active-low, bouncy (asynchronous)
//   input1, input2   - captured operands A and B
//   sum, overflow    - A+B mod 16 and signed overflow of A+B
//   result_valid     - sum/overflow reflect the current operands
//   state[1:0]       - FSM state for LEDs
module operand_adder_seq #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] sw,
  input  logic       key_n,
  output logic [3:0] input1,
  output logic [3:0] input2,
  output logic [3:0] sum,
  output logic       overflow,
  output logic       result_valid,
  output logic [1:0] state
);

  localparam int unsigned OP_W  = 4;
  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  typedef enum logic [1:0] {
    LOAD_A = 2'b00,
    LOAD_B = 2'b01,
    CALC   = 2'b10,
    SHOW   = 2'b11
  } state_e;

  logic             key_meta_q, key_meta_d;
  logic             key_sync_q, key_sync_d;
  logic [OP_W-1:0]  sw_meta_q, sw_meta_d;
  logic [OP_W-1:0]  sw_sync_q, sw_sync_d;
  logic             db_key_q, db_key_d;
  logic [CNT_W-1:0] db_cnt_q, db_cnt_d;
  logic             press_q, press_d;
  state_e           state_q, state_d;
  logic [OP_W-1:0]  input1_q, input1_d;
  logic [OP_W-1:0]  input2_q, input2_d;
  logic [OP_W-1:0]  sum_q, sum_d;
  logic             overflow_q, overflow_d;
  logic             valid_q, valid_d;
  logic [OP_W-1:0]  sum_calc;

  // Two-flop synchronizers for the asynchronous key and switches.
  always_comb begin
    key_meta_d = key_n;
    key_sync_d = key_meta_q;
    sw_meta_d  = sw;
    sw_sync_d  = sw_meta_q;
  end

  // Debounce: count consecutive cycles the synced key disagrees with the
  // debounced level; any agreement restarts the count. A press pulse is
  // registered on the debounced 1->0 change only.
  always_comb begin
    db_key_d = db_key_q;
    db_cnt_d = db_cnt_q;
    press_d  = 1'b0;
    if (key_sync_q == db_key_q) begin
      db_cnt_d = '0;
    end else if (db_cnt_q == CNT_W'(DEBOUNCE_CYCLES)) begin
      db_key_d = key_sync_q;
      db_cnt_d = '0;
      press_d  = ~key_sync_q;
    end else begin
      db_cnt_d = db_cnt_q + CNT_W'(1);
    end
  end

  assign sum_calc = input1_q + input2_q;

  // Operand entry / result FSM.
  always_comb begin
    state_d    = state_q;
    input1_d   = input1_q;
    input2_d   = input2_q;
    sum_d      = sum_q;
    overflow_d = overflow_q;
    valid_d    = valid_q;
    unique case (state_q)
      LOAD_A: begin
        if (press_q) begin
          input1_d = sw_sync_q;
          state_d  = LOAD_B;
        end
      end
      LOAD_B: begin
        if (press_q) begin
          input2_d = sw_sync_q;
          state_d  = CALC;
        end
      end
      CALC: begin
        sum_d      = sum_calc;
        overflow_d = (input1_q[OP_W-1] == input2_q[OP_W-1]) &&
                     (sum_calc[OP_W-1] != input1_q[OP_W-1]);
        valid_d    = 1'b1;
        state_d    = SHOW;
      end
      SHOW: begin
        // A new press starts the next entry with operand A already captured.
        if (press_q) begin
          input1_d   = sw_sync_q;
          input2_d   = '0;
          sum_d      = '0;
          overflow_d = 1'b0;
          valid_d    = 1'b0;
          state_d    = LOAD_B;
        end
      end
      default: state_d = LOAD_A;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_meta_q <= 1'b1;
      key_sync_q <= 1'b1;
      sw_meta_q  <= '0;
      sw_sync_q  <= '0;
      db_key_q   <= 1'b1;
      db_cnt_q   <= '0;
      press_q    <= 1'b0;
      state_q    <= LOAD_A;
      input1_q   <= '0;
      input2_q   <= '0;
      sum_q      <= '0;
      overflow_q <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      key_meta_q <= key_meta_d;
      key_sync_q <= key_sync_d;
      sw_meta_q  <= sw_meta_d;
      sw_sync_q  <= sw_sync_d;
      db_key_q   <= db_key_d;
      db_cnt_q   <= db_cnt_d;
      press_q    <= press_d;
      state_q    <= state_d;
      input1_q   <= input1_d;
      input2_q   <= input2_d;
      sum_q      <= sum_d;
      overflow_q <= overflow_d;
      valid_q    <= valid_d;
    end
  end

  assign input1       = input1_q;
  assign input2       = input2_q;
  assign sum          = sum_q;
  assign overflow     = overflow_q;
  assign result_valid = valid_q;
  assign state        = state_q;

endmodule

// File: tb/tb_operand_adder_seq.sv
// Self-checking bench for operand_adder_seq with DEBOUNCE_CYCLES = 4.
module tb_operand_adder_seq;

  localparam int unsigned DB      = 4;
  localparam int unsigned NVEC    = 7;
  localparam int          LATENCY = 8;  // negedges from key low to capture visible

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] sw;
  logic       key_n;
  logic [3:0] input1, input2, sum;
  logic       overflow, result_valid;
  logic [1:0] state;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] exp_sum;
    logic       exp_ovf;
  } vec_t;

  vec_t vec [NVEC];

  operand_adder_seq #(.DEBOUNCE_CYCLES(DB)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sw           (sw),
    .key_n        (key_n),
    .input1       (input1),
    .input2       (input2),
    .sum          (sum),
    .overflow     (overflow),
    .result_valid (result_valid),
    .state        (state)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_input1"}, 8'(input1), 8'h0);
    check({tag, "_input2"}, 8'(input2), 8'h0);
    check({tag, "_sum"}, 8'(sum), 8'h0);
    check({tag, "_ovf"}, 8'(overflow), 8'h0);
    check({tag, "_valid"}, 8'(result_valid), 8'h0);
    check({tag, "_state"}, 8'(state), 8'h0);
  endtask

  // Called at a negedge: drive sw and key low, wait (bounded) for the state to move.
  task automatic press(input logic [3:0] v, output int cycles);
    logic [1:0] st0;
    st0    = state;
    sw     = v;
    key_n  = 1'b0;
    cycles = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (state !== st0) begin
        cycles = i;
        break;
      end
    end
  endtask

  task automatic release_key();
    key_n = 1'b1;
    repeat (20) @(negedge clk);
  endtask

  initial begin
    int cyc;
    vec[0] = '{4'h3, 4'h2, 4'h5, 1'b0};
    vec[1] = '{4'h7, 4'h1, 4'h8, 1'b1};
    vec[2] = '{4'h8, 4'hF, 4'h7, 1'b1};
    vec[3] = '{4'hF, 4'h1, 4'h0, 1'b0};
    vec[4] = '{4'h4, 4'h4, 4'h8, 1'b1};
    vec[5] = '{4'h8, 4'h8, 4'h0, 1'b1};
    vec[6] = '{4'h5, 4'hD, 4'h2, 1'b0};

    rst_n = 1'b0;
    key_n = 1'b1;
    sw    = 4'h0;
    #2;
    check_all_zero("reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Short glitches must not produce a capture.
    sw    = 4'h9;
    key_n = 1'b0;
    repeat (3) @(negedge clk);
    key_n = 1'b1;
    repeat (3) @(negedge clk);
    key_n = 1'b0;
    repeat (2) @(negedge clk);
    key_n = 1'b1;
    repeat (20) @(negedge clk);
    check("glitch_state", 8'(state), 8'h0);
    check("glitch_input1", 8'(input1), 8'h0);

    for (int i = 0; i < NVEC; i++) begin
      // Operand A (from LOAD_A first, then from SHOW re-entry).
      press(vec[i].a, cyc);
      check($sformatf("v%0d_a_latency", i), 8'(cyc), 8'(LATENCY));
      check($sformatf("v%0d_a_state", i), 8'(state), 8'h1);
      check($sformatf("v%0d_a_input1", i), 8'(input1), 8'(vec[i].a));
      check($sformatf("v%0d_a_input2", i), 8'(input2), 8'h0);
      check($sformatf("v%0d_a_sum", i), 8'(sum), 8'h0);
      check($sformatf("v%0d_a_ovf", i), 8'(overflow), 8'h0);
      check($sformatf("v%0d_a_valid", i), 8'(result_valid), 8'h0);
      if (i == 0) begin
        // Long hold with switches changing: still exactly one capture.
        sw = 4'hA;
        repeat (92) @(negedge clk);
        check("hold_state", 8'(state), 8'h1);
        check("hold_input1", 8'(input1), 8'h3);
      end
      release_key();

      // Operand B, then the one-cycle CALC step.
      press(vec[i].b, cyc);
      check($sformatf("v%0d_b_latency", i), 8'(cyc), 8'(LATENCY));
      check($sformatf("v%0d_b_state", i), 8'(state), 8'h2);
      check($sformatf("v%0d_b_input2", i), 8'(input2), 8'(vec[i].b));
      check($sformatf("v%0d_b_valid", i), 8'(result_valid), 8'h0);
      @(negedge clk);
      check($sformatf("v%0d_show_state", i), 8'(state), 8'h3);
      check($sformatf("v%0d_sum", i), 8'(sum), 8'(vec[i].exp_sum));
      check($sformatf("v%0d_ovf", i), 8'(overflow), 8'(vec[i].exp_ovf));
      check($sformatf("v%0d_valid", i), 8'(result_valid), 8'h1);
      check($sformatf("v%0d_show_input1", i), 8'(input1), 8'(vec[i].a));
      sw = ~vec[i].b;
      release_key();
      check($sformatf("v%0d_hold_state", i), 8'(state), 8'h3);
      check($sformatf("v%0d_hold_sum", i), 8'(sum), 8'(vec[i].exp_sum));
      check($sformatf("v%0d_hold_input2", i), 8'(input2), 8'(vec[i].b));
    end

    // Reset while in LOAD_B discards operand A; next press captures A again.
    press(4'h5, cyc);
    check("mid_state", 8'(state), 8'h1);
    check("mid_input1", 8'(input1), 8'h5);
    release_key();
    #3;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    press(4'h6, cyc);
    check("post_reset_latency", 8'(cyc), 8'(LATENCY));
    check("post_reset_state", 8'(state), 8'h1);
    check("post_reset_input1", 8'(input1), 8'h6);
    check("post_reset_input2", 8'(input2), 8'h0);
    release_key();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
